video_rx_capture: RTL and testbench
===================================

# video_rx_capture

Pixel-bus receiver for the parallel RGB video interface (24-bit RGB, HD, VD, DEN) driven by the system's video output. It samples the bus in the pixel clock domain, checks the line and frame geometry, and buffers active pixels in a small FIFO. Pixels leave on an Avalon-ST source with start-of-packet/end-of-packet framing, one packet per frame. It sits at the end of the video path as a loopback and capture block for on-board self-test and frame grabbing.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- video_RGB_IN  in  24  pixel data {R,G,B}.
- video_HD  in  1  horizontal sync, active low.
- video_VD  in  1  vertical sync, active low.
- video_DEN  in  1  data enable, active high.
- src_data  out  24  streamed pixel.
- src_valid  out  1  src_data valid.
- src_ready  in  1  downstream accepts.
- src_startofpacket  out  1  first pixel of frame.
- src_endofpacket  out  1  last pixel of frame.
- frame_count  out  16  completed good frames; wraps 0xFFFF to 0.
- line_err  out  1  sticky: line with pixel count ≠ H_ACTIVE.
- frame_err  out  1  sticky: frame with line count ≠ V_ACTIVE.
- overflow  out  1  sticky: pixel dropped because the FIFO was full.
- meas_h  out  12  pixel count of the last completed line.
- meas_v  out  12  line count of the last completed frame.

## Operation
- All five video inputs are registered once (stage S1). Edge detection compares S1 with a second register (S2).
- Frame start: VD falling edge at S1.
- FSM states:
  - SEEK: after reset; discards everything. On VD fall, go to FRAME.
  - FRAME: counts pixels and lines; pushes every pixel with DEN high into the FIFO.
  - RESYNC: entered from FRAME on overflow; discards until the next VD fall, then goes to FRAME.
- Pixel counter: increments on each S1 DEN-high cycle. At a DEN falling edge it does the following:
  - latches into meas_h;
  - sets line_err if ≠ H_ACTIVE;
  - clears;
  - increments the line counter.
- At VD fall while in FRAME, the line counter does the following:
  - latches into meas_v;
  - sets frame_err if ≠ V_ACTIVE, otherwise increments frame_count;
  - clears.
- A VD fall taken from RESYNC does not touch frame_count or frame_err.
- FIFO entries are 26 bits: {eop, sop, rgb}.
  - sop = 1 on the first DEN pixel after a VD fall.
  - eop = 1 when line = V_ACTIVE−1 and pixel = H_ACTIVE−1.
  - Extra pixels beyond the geometry are pushed with eop = 0.
- The FIFO is show-ahead. src_valid = not empty. A pop occurs when src_valid and src_ready are both high.
- Full FIFO with a push and no pop in the same cycle: the pixel is dropped, overflow is set, and the FSM goes to RESYNC. Entries already in the FIFO still drain.
- Full FIFO with a push and a pop in the same cycle: the push is accepted and the count is unchanged.
- Empty FIFO: src_valid is low. src_data, src_startofpacket and src_endofpacket hold their last values and are don't-care.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - src_valid, src_startofpacket, src_endofpacket, line_err, frame_err, overflow = 0;
  - src_data, frame_count, meas_h, meas_v = 0;
  - FSM in SEEK; FIFO empty; all counters 0.
- Latency: a pixel sampled at edge N, with the FIFO empty and src_ready high, appears on src_data with src_valid = 1 after edge N+2.
- Throughput: one pixel per clock, sustained while src_ready = 1.
- meas_h and line_err update at edge N+2, where edge N samples DEN low after high.
- meas_v, frame_err and frame_count update at edge N+2, where edge N samples the VD fall.
- Reset mid-frame: the FIFO is flushed, the FSM returns to SEEK, and no partial packet is emitted afterwards.
- A VD fall coinciding with DEN high is treated as frame end followed by the first pixel of the new frame; that pixel gets sop = 1.

## Configuration
- VIDEO_RX_MEASURE_EN:
  - Defined: meas_h, meas_v, line_err and frame_err logic is built as described.
  - Undefined: these four outputs are tied to 0 and their counters and comparators are removed.
  - frame_count, overflow and streaming are always present. Without the macro, frame_count increments on every VD fall taken from FRAME.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, FIFO_DEPTH=16.
- Two clean frames, each 4 lines of 8 DEN pixels with data = pixel index, src_ready = 1 → 32 beats per frame. sop only on beat 0 (data 0x000000); eop only on beat 31. frame_count = 1 after the second VD fall; meas_h = 8, meas_v = 4; no flags.
- One line carrying 7 DEN pixels → meas_h = 7, line_err = 1. At the following VD fall frame_err stays 0 (lines = 4). No eop is emitted for that frame.
- Frame with 5 lines → at the next VD fall frame_err = 1, meas_v = 5, frame_count unchanged.
- src_ready held low for a 20-pixel burst → 16 entries accepted, overflow = 1, FSM in RESYNC. After src_ready goes high, exactly 16 beats drain. Next frame streams with sop on its first beat.
- src_ready toggling 1/0 every cycle during a frame → no pixel lost or duplicated; beat order matches input order.
- Reset asserted at pixel 3 of line 2 → outputs at their reset values on the next edge. The following VD fall and frame produce a full 32-beat packet with frame_count = 0 until that frame completes.

Source files
------------

// File: rtl/video_rx_capture.sv
// video_rx_capture
// Pixel-bus receiver for the parallel RGB video interface. Samples the bus in
// the pixel clock domain, checks line/frame geometry, buffers active pixels in
// a show-ahead FIFO and streams them out as one Avalon-ST packet per frame.
//
// Optional feature macro: VIDEO_RX_MEASURE_EN
//   defined   -> meas_h, meas_v, line_err, frame_err are built; frame_count
//                only counts frames whose line count equals V_ACTIVE.
//   undefined -> those four outputs are tied to 0; frame_count counts every
//                VD fall that closes a frame.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   video_RGB_IN[23:0]    pixel data {R,G,B}
//   video_HD, video_VD    horizontal / vertical sync, active low
//   video_DEN             data enable, active high
//   src_data[23:0]        streamed pixel
//   src_valid/src_ready   Avalon-ST handshake
//   src_startofpacket     first pixel of frame
//   src_endofpacket       last pixel of frame
//   frame_count[15:0]     completed good frames (wraps)
//   line_err, frame_err   sticky geometry errors
//   overflow              sticky: pixel dropped on full FIFO
//   meas_h[11:0]          pixel count of last completed line
//   meas_v[11:0]          line count of last completed frame
module video_rx_capture #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] video_RGB_IN,
  input  logic        video_HD,
  input  logic        video_VD,
  input  logic        video_DEN,
  output logic [23:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  output logic [15:0] frame_count,
  output logic        line_err,
  output logic        frame_err,
  output logic        overflow,
  output logic [11:0] meas_h,
  output logic [11:0] meas_v
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH  = CW'(FIFO_DEPTH);
  localparam logic [11:0]   LP_H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0]   LP_V_LAST = 12'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    FRAME  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  logic [23:0] r_rgb1;
  logic        r_hd1, r_vd1, r_den1, r_vd2, r_den2;
  logic        w_vdFall, w_denFall, w_counting, w_unused;
  state_t      r_state, w_nextState;
  logic        w_frameActive, w_frameClose;
  logic [11:0] r_pixCnt, r_lineCnt, w_pixIdx, w_lineIdx;
  logic        r_sopPending, w_push, w_sopFlag, w_eopFlag;
  logic        r_pushValid;
  logic [25:0] r_pushData;
  logic [25:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr, r_rdPtr;
  logic [CW-1:0] r_count;
  logic        w_empty, w_full, w_pop, w_wr, w_drop;
  logic        r_overflow;
  logic [15:0] r_frameCount;

  // Input registers: S1 is the sampled bus, S2 delays VD/DEN for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb1 <= '0;
      r_hd1  <= 1'b0;
      r_vd1  <= 1'b0;
      r_den1 <= 1'b0;
      r_vd2  <= 1'b0;
      r_den2 <= 1'b0;
    end else begin
      r_rgb1 <= video_RGB_IN;
      r_hd1  <= video_HD;
      r_vd1  <= video_VD;
      r_den1 <= video_DEN;
      r_vd2  <= r_vd1;
      r_den2 <= r_den1;
    end
  end

  // HD is sampled with the rest of the bus but geometry is derived from DEN.
  assign w_unused   = r_hd1;
  assign w_vdFall   = r_vd2 & ~r_vd1;
  assign w_denFall  = r_den2 & ~r_den1;
  assign w_counting = (r_state == FRAME);

  // FIFO status; a drop happens only when full with no pop to make room.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_pop   = ~w_empty & src_ready;
  assign w_wr    = r_pushValid & (~w_full | w_pop);
  assign w_drop  = r_pushValid & w_full & ~w_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= SEEK;
    else       r_state <= w_nextState;
  end

  // Next state. A VD fall opens a frame from any state, so the pixel sampled
  // together with that fall already belongs to the new frame.
  always_comb begin
    w_nextState   = r_state;
    w_frameActive = 1'b0;
    w_frameClose  = 1'b0;
    unique case (r_state)
      SEEK, RESYNC: begin
        if (w_vdFall) begin
          w_nextState   = FRAME;
          w_frameActive = 1'b1;
        end
      end
      FRAME: begin
        w_frameActive = 1'b1;
        w_frameClose  = w_vdFall;
        if (w_drop) w_nextState = RESYNC;
      end
      default: w_nextState = SEEK;
    endcase
  end

  // On a VD fall the current pixel is pixel 0 of line 0 of the new frame.
  assign w_push    = w_frameActive & r_den1;
  assign w_sopFlag = w_vdFall | r_sopPending;
  assign w_pixIdx  = w_vdFall ? 12'd0 : r_pixCnt;
  assign w_lineIdx = w_vdFall ? 12'd0 : r_lineCnt;
  assign w_eopFlag = (w_lineIdx == LP_V_LAST) && (w_pixIdx == LP_H_LAST);

  // Geometry counters and the push staging register. A dropped pixel also
  // kills the pixel staged behind it so nothing out of order reaches the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixCnt     <= '0;
      r_lineCnt    <= '0;
      r_sopPending <= 1'b0;
      r_pushValid  <= 1'b0;
      r_pushData   <= '0;
    end else begin
      r_pushValid <= w_push & ~w_drop;
      r_pushData  <= {w_eopFlag, w_sopFlag, r_rgb1};
      if (w_vdFall) begin
        r_pixCnt     <= {11'd0, r_den1};
        r_lineCnt    <= '0;
        r_sopPending <= ~r_den1;
      end else if (w_counting) begin
        if (r_den1) begin
          r_pixCnt     <= r_pixCnt + 12'd1;
          r_sopPending <= 1'b0;
        end else if (w_denFall) begin
          r_pixCnt  <= '0;
          r_lineCnt <= r_lineCnt + 12'd1;
        end
      end
    end
  end

  // Show-ahead FIFO; memory is cleared on reset so src_data resets to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wrPtr] <= r_pushData;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign {src_endofpacket, src_startofpacket, src_data} = r_mem[r_rdPtr];
  assign src_valid   = ~w_empty;
  assign overflow    = r_overflow;
  assign frame_count = r_frameCount;

`ifdef VIDEO_RX_MEASURE_EN
  logic        w_lineDone, r_lineDone, r_frameDone;
  logic [11:0] w_frameLines, r_lineLen, r_frameLines, r_measH, r_measV;
  logic        r_lineErr, r_frameErr;

  // A line that ends on the same cycle as the VD fall still counts.
  assign w_lineDone   = w_counting & w_denFall;
  assign w_frameLines = r_lineCnt + {11'd0, w_lineDone};

  // Line/frame results are captured one cycle after the edge, then evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lineDone   <= 1'b0;
      r_frameDone  <= 1'b0;
      r_lineLen    <= '0;
      r_frameLines <= '0;
      r_measH      <= '0;
      r_measV      <= '0;
      r_lineErr    <= 1'b0;
      r_frameErr   <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_lineDone   <= w_lineDone;
      r_lineLen    <= r_pixCnt;
      r_frameDone  <= w_frameClose;
      r_frameLines <= w_frameLines;
      if (r_lineDone) begin
        r_measH <= r_lineLen;
        if (r_lineLen != 12'(H_ACTIVE)) r_lineErr <= 1'b1;
      end
      if (r_frameDone) begin
        r_measV <= r_frameLines;
        if (r_frameLines != 12'(V_ACTIVE)) r_frameErr <= 1'b1;
        else                               r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  assign meas_h    = r_measH;
  assign meas_v    = r_measV;
  assign line_err  = r_lineErr;
  assign frame_err = r_frameErr;
`else
  logic r_frameDone;

  // Without measurement every frame closed from FRAME is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameDone  <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_frameDone <= w_frameClose;
      if (r_frameDone) r_frameCount <= r_frameCount + 16'd1;
    end
  end

  assign meas_h    = '0;
  assign meas_v    = '0;
  assign line_err  = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_rx_capture.sv
// tb_video_rx_capture
// Self-checking bench for video_rx_capture with H_ACTIVE=8, V_ACTIVE=4,
// FIFO_DEPTH=16. Frame scenarios come from a table of records holding the
// frame shape and the hand-computed expected results; overflow, reset and
// latency corner cases are hand-written sequences.
module tb_video_rx_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] video_RGB_IN;
  logic        video_HD, video_VD, video_DEN;
  logic [23:0] src_data;
  logic        src_valid, src_ready, src_startofpacket, src_endofpacket;
  logic [15:0] frame_count;
  logic        line_err, frame_err, overflow;
  logic [11:0] meas_h, meas_v;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    tag;
    int    nLines;
    int    lastPix;
    bit    toggleReady;
    int    expBeats;
    int    expMeasH;
    int    expMeasV;
    bit    expLineErr;
    bit    expFrameErr;
    int    fcDelta;
  } vec_t;

  vec_t        vecs[5];
  vec_t        postResync, afterReset;
  logic [25:0] beatQ[$];
  logic [25:0] expQ[$];
  logic [15:0] expFc;
  logic        expOverflow;

  video_rx_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .video_RGB_IN(video_RGB_IN),
    .video_HD(video_HD), .video_VD(video_VD), .video_DEN(video_DEN),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
    .frame_count(frame_count), .line_err(line_err), .frame_err(frame_err),
    .overflow(overflow), .meas_h(meas_h), .meas_v(meas_v)
  );

  always #5 clk = ~clk;

  // Beats are collected half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (!reset && src_valid && src_ready)
      beatQ.push_back({src_endofpacket, src_startofpacket, src_data});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame body: line l has H pixels except the last which has lastPix.
  task automatic sendLines(input int tag, input int nLines, input int lastPix,
                           input bit toggle);
    int idx = 0;
    for (int l = 0; l < nLines; l++) begin
      int n = (l == nLines - 1) ? lastPix : H;
      for (int p = 0; p < n; p++) begin
        video_RGB_IN = {8'(tag), 16'(idx)};
        video_DEN    = 1'b1;
        video_HD     = 1'b1;
        if (toggle) src_ready = ~src_ready;
        step();
        idx++;
      end
      video_DEN = 1'b0;
      for (int k = 0; k < 4; k++) begin
        video_HD = (k < 2) ? 1'b0 : 1'b1;
        if (toggle) src_ready = ~src_ready;
        step();
      end
    end
  endtask

  task automatic genExpected(input int tag, input int nLines, input int lastPix);
    int idx = 0;
    for (int l = 0; l < nLines; l++) begin
      int n = (l == nLines - 1) ? lastPix : H;
      for (int p = 0; p < n; p++) begin
        logic sop, eop;
        sop = (l == 0) && (p == 0);
        eop = (l == V - 1) && (p == H - 1);
        expQ.push_back({eop, sop, 8'(tag), 16'(idx)});
        idx++;
      end
    end
  endtask

  task automatic vdPulse();
    video_DEN = 1'b0;
    video_VD  = 1'b0;
    step();
    step();
    video_VD = 1'b1;
    repeat (4) step();
  endtask

  task automatic compareBeats(input string name);
    int waitCnt = 0;
    while ((beatQ.size() < expQ.size() || src_valid) && waitCnt < 400) begin
      step();
      waitCnt++;
    end
    repeat (4) step();
    checkOutput({name, "_beats"}, 32'(beatQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < beatQ.size(); i++)
      checkOutput($sformatf("%s_beat%0d", name, i), 32'(beatQ[i]), 32'(expQ[i]));
    beatQ.delete();
    expQ.delete();
  endtask

  task automatic checkStatus(input vec_t v);
    checkOutput({v.name, "_frame_count"}, 32'(frame_count), 32'(expFc));
    checkOutput({v.name, "_overflow"}, 32'(overflow), 32'(expOverflow));
`ifdef VIDEO_RX_MEASURE_EN
    checkOutput({v.name, "_meas_h"}, 32'(meas_h), 32'(v.expMeasH));
    checkOutput({v.name, "_meas_v"}, 32'(meas_v), 32'(v.expMeasV));
    checkOutput({v.name, "_line_err"}, 32'(line_err), 32'(v.expLineErr));
    checkOutput({v.name, "_frame_err"}, 32'(frame_err), 32'(v.expFrameErr));
`else
    checkOutput({v.name, "_meas_h"}, 32'(meas_h), 32'd0);
    checkOutput({v.name, "_meas_v"}, 32'(meas_v), 32'd0);
    checkOutput({v.name, "_line_err"}, 32'(line_err), 32'd0);
    checkOutput({v.name, "_frame_err"}, 32'(frame_err), 32'd0);
`endif
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_src_valid"}, 32'(src_valid), 32'd0);
    checkOutput({name, "_sop"}, 32'(src_startofpacket), 32'd0);
    checkOutput({name, "_eop"}, 32'(src_endofpacket), 32'd0);
    checkOutput({name, "_src_data"}, 32'(src_data), 32'd0);
    checkOutput({name, "_frame_count"}, 32'(frame_count), 32'd0);
    checkOutput({name, "_line_err"}, 32'(line_err), 32'd0);
    checkOutput({name, "_frame_err"}, 32'(frame_err), 32'd0);
    checkOutput({name, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({name, "_meas_h"}, 32'(meas_h), 32'd0);
    checkOutput({name, "_meas_v"}, 32'(meas_v), 32'd0);
  endtask

  // The first pixel is sampled at edge N and must be visible after edge N+2.
  task automatic latencyProbe(input int tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_n0_valid", 32'(src_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_n1_valid", 32'(src_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_n2_valid", 32'(src_valid), 32'd1);
    checkOutput("latency_n2_data", 32'(src_data), 32'({8'(tag), 16'd0}));
    checkOutput("latency_n2_sop", 32'(src_startofpacket), 32'd1);
  endtask

  // One frame body, its closing VD fall, then beats and status against the record.
  task automatic applyStimulus(input vec_t v, input bit probe);
    genExpected(v.tag, v.nLines, v.lastPix);
    if (probe) begin
      fork
        sendLines(v.tag, v.nLines, v.lastPix, v.toggleReady);
        latencyProbe(v.tag);
      join
    end else begin
      sendLines(v.tag, v.nLines, v.lastPix, v.toggleReady);
    end
    src_ready = 1'b1;
    vdPulse();
`ifdef VIDEO_RX_MEASURE_EN
    expFc = expFc + 16'(v.fcDelta);
`else
    expFc = expFc + 16'd1;
`endif
    checkOutput({v.name, "_expected_beats"}, 32'(expQ.size()), 32'(v.expBeats));
    compareBeats(v.name);
    checkStatus(v);
  endtask

  initial begin
    //          name         tag lines last tog beats mH mV le fe dFc
    vecs[0] = '{"clean0",     0, 4, 8, 1'b0, 32, 8, 4, 1'b0, 1'b0, 1};
    vecs[1] = '{"clean1",     1, 4, 8, 1'b0, 32, 8, 4, 1'b0, 1'b0, 1};
    vecs[2] = '{"toggle",     2, 4, 8, 1'b1, 32, 8, 4, 1'b0, 1'b0, 1};
    vecs[3] = '{"shortLine",  3, 4, 7, 1'b0, 31, 7, 4, 1'b1, 1'b0, 1};
    vecs[4] = '{"fiveLines",  4, 5, 8, 1'b0, 40, 8, 5, 1'b1, 1'b1, 0};
    postResync = '{"postResync", 6, 4, 8, 1'b0, 32, 8, 4, 1'b1, 1'b1, 1};
    afterReset = '{"afterReset", 8, 4, 8, 1'b0, 32, 8, 4, 1'b0, 1'b0, 1};

    reset        = 1'b1;
    video_RGB_IN = '0;
    video_HD     = 1'b1;
    video_VD     = 1'b1;
    video_DEN    = 1'b0;
    src_ready    = 1'b1;
    expFc        = '0;
    expOverflow  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    checkResetState("init");
    step();

    vdPulse();
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i == 0);

    $display("[TB] overflow burst with src_ready low");
    src_ready = 1'b0;
    genExpected(5, 1, 20);
    while (expQ.size() > D) void'(expQ.pop_back());
    sendLines(5, 1, 20, 1'b0);
    repeat (2) step();
    checkOutput("ovf_overflow", 32'(overflow), 32'd1);
    checkOutput("ovf_src_valid", 32'(src_valid), 32'd1);
    expOverflow = 1'b1;
    src_ready = 1'b1;
    compareBeats("overflowDrain");
    vdPulse();
    checkOutput("resync_vd_frame_count", 32'(frame_count), 32'(expFc));
    applyStimulus(postResync, 1'b0);

    $display("[TB] reset at pixel 3 of line 2");
    sendLines(7, 2, H, 1'b0);
    for (int p = 0; p < 3; p++) begin
      video_RGB_IN = {8'd7, 16'(2 * H + p)};
      video_DEN    = 1'b1;
      step();
    end
    video_RGB_IN = {8'd7, 16'(2 * H + 3)};
    reset = 1'b1;
    step();
    reset     = 1'b0;
    video_DEN = 1'b0;
    checkResetState("midReset");
    beatQ.delete();
    expQ.delete();
    expFc       = '0;
    expOverflow = 1'b0;
    repeat (4) step();
    checkOutput("midReset_no_beats", 32'(beatQ.size()), 32'd0);
    vdPulse();
    checkOutput("afterReset_open_frame_count", 32'(frame_count), 32'd0);
    applyStimulus(afterReset, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
